// File: rtl/sdr_pkg.sv
// Shared SDR datapath definitions: payload word layout,
// DAC buffer state encoding and statistics counter helpers.
package sdr_pkg;

  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } buf_state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Saturating increment for the CPU-visible statistics.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             ev
  );
    if (ev && cnt != CNT_MAX)
      return cnt + 1'b1;
    return cnt;
  endfunction

endpackage

// File: rtl/dac_fifo_ram.sv
// Simple dual-port sample storage, one write port and one
// registered read port so it maps onto block RAM.
module dac_fifo_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/dac_sample_buffer.sv
// DAC sample FIFO with prefill hold-off, underrun recovery
// and saturating overflow/underflow/packet-loss statistics.
module dac_sample_buffer
  import sdr_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          PREFILL    = 512,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              packet_loss_i,
  input  logic              sample_en,
  input  logic              flush,
  input  logic              clear_stats,
  output logic [15:0]       dac_i,
  output logic [15:0]       dac_q,
  output logic              dac_valid,
  output logic              streaming,
  output logic [ADDR_W:0]   fifo_level,
  output logic [CNT_W-1:0]  overflow_cnt,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic [CNT_W-1:0]  loss_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PRE_LVL  = (ADDR_W+1)'(PREFILL);

  buf_state_t        state;
  buf_state_t        state_nx;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              pop;
  logic              wr_ok;
  logic              ovf_ev;
  logic              unf_ev;
  logic              loss_ev;
  logic              loss_q;
  logic              loss_qq;
  logic              idle;
  logic [31:0]       rd_data;

  // Handshake decisions; flush overrides both write and pop.
  always_comb begin
    full    = (level == FULL_LVL);
    empty   = (level == '0);
    pop     = (state == STREAM) && sample_en
              && !empty && !flush;
    wr_ok   = wr_en && !flush && (!full || pop);
    ovf_ev  = wr_en && !flush && full && !pop;
    unf_ev  = (state == STREAM) && sample_en && empty;
    loss_ev = loss_q && !loss_qq;
  end

  // Next state: prefill on the registered level, drop on underrun.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = FILL;
    end else begin
      unique case (state)
        FILL:   if (level >= PRE_LVL) state_nx = STREAM;
        STREAM: if (unf_ev)           state_nx = FILL;
        default:                      state_nx = FILL;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= FILL;
    else
      state <= state_nx;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      unique case ({wr_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Output qualification; idle masks stale RAM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_valid <= 1'b0;
      idle      <= 1'b1;
    end else begin
      dac_valid <= pop;
      if (flush || unf_ev)
        idle <= 1'b1;
      else if (pop)
        idle <= 1'b0;
    end
  end

  // Packet-loss edge detect and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_q        <= 1'b0;
      loss_qq       <= 1'b0;
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
      loss_cnt      <= '0;
    end else begin
      loss_q  <= packet_loss_i;
      loss_qq <= loss_q;
      if (clear_stats) begin
        overflow_cnt  <= '0;
        underflow_cnt <= '0;
        loss_cnt      <= '0;
      end else begin
        overflow_cnt  <= sat_inc(overflow_cnt, ovf_ev);
        underflow_cnt <= sat_inc(underflow_cnt, unf_ev);
        loss_cnt      <= sat_inc(loss_cnt, loss_ev);
      end
    end
  end

  dac_fifo_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rptr),
    .rdata (rd_data)
  );

  assign dac_i      = idle ? IDLE_VALUE : rd_data[I_MSB:I_LSB];
  assign dac_q      = idle ? IDLE_VALUE : rd_data[Q_MSB:Q_LSB];
  assign streaming  = (state == STREAM);
  assign fifo_level = level;

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Directed bench for dac_sample_buffer with DEPTH=8, PREFILL=4:
// vector table for prefill/underrun/flush, hand sequences for the rest.
module tb_dac_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        packet_loss_i;
  logic        sample_en;
  logic        flush;
  logic        clear_stats;
  logic [15:0] dac_i;
  logic [15:0] dac_q;
  logic        dac_valid;
  logic        streaming;
  logic [3:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic [15:0] underflow_cnt;
  logic [15:0] loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_sample_buffer #(
    .ADDR_W     (3),
    .PREFILL    (4),
    .IDLE_VALUE (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .packet_loss_i (packet_loss_i),
    .sample_en     (sample_en),
    .flush         (flush),
    .clear_stats   (clear_stats),
    .dac_i         (dac_i),
    .dac_q         (dac_q),
    .dac_valid     (dac_valid),
    .streaming     (streaming),
    .fifo_level    (fifo_level),
    .overflow_cnt  (overflow_cnt),
    .underflow_cnt (underflow_cnt),
    .loss_cnt      (loss_cnt)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        smp;
    logic        fl;
    logic [3:0]  lvl;
    logic        str;
    logic        vld;
    logic [15:0] i;
    logic [15:0] q;
  } vec_t;

  vec_t tbl [25];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    sample_en = 1'b0;
    flush = 1'b0;
    clear_stats = 1'b0;
    packet_loss_i = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic strobe_check(input string nm,
                              input logic [31:0] exp);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    check({nm, "_valid"}, 32'(dac_valid), 32'd1);
    check({nm, "_data"}, {dac_i, dac_q}, exp);
  endtask

  initial begin
    // wr, data, smp, flush | level, streaming, valid, i, q
    tbl[0]  = '{1'b1, 32'h00010002, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 32'h00030004, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 32'h00050006, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 32'h00070008, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 16'h0001, 16'h0002};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 16'h0001, 16'h0002};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 16'h0001, 16'h0002};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 16'h0001, 16'h0002};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 16'h0003, 16'h0004};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0003, 16'h0004};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 16'h0005, 16'h0006};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 16'h0007, 16'h0008};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[15] = '{1'b1, 32'h11112222, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[16] = '{1'b1, 32'h33334444, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[17] = '{1'b1, 32'h55556666, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[18] = '{1'b1, 32'h77778888, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[20] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 16'h1111, 16'h2222};
    tbl[21] = '{1'b1, 32'h9999AAAA, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 16'h1111, 16'h2222};
    tbl[22] = '{1'b1, 32'hBBBBCCCC, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 16'h1111, 16'h2222};
    tbl[23] = '{1'b1, 32'hDDDDEEEE, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[24] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    wr_data = '0;
    do_reset();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_stream", 32'(streaming), 32'd0);
    check("rst_valid", 32'(dac_valid), 32'd0);
    check("rst_dac", {dac_i, dac_q}, 32'h0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    check("rst_unf", 32'(underflow_cnt), 32'd0);
    check("rst_loss", 32'(loss_cnt), 32'd0);

    // Prefill, streaming, underrun, refill, flush mid-stream.
    for (int k = 0; k < 25; k++) begin
      wr_en     = tbl[k].wr;
      wr_data   = tbl[k].data;
      sample_en = tbl[k].smp;
      flush     = tbl[k].fl;
      step();
      check($sformatf("v%0d_level", k), 32'(fifo_level), 32'(tbl[k].lvl));
      check($sformatf("v%0d_stream", k), 32'(streaming), 32'(tbl[k].str));
      check($sformatf("v%0d_valid", k), 32'(dac_valid), 32'(tbl[k].vld));
      check($sformatf("v%0d_i", k), 32'(dac_i), 32'(tbl[k].i));
      check($sformatf("v%0d_q", k), 32'(dac_q), 32'(tbl[k].q));
    end
    wr_en = 1'b0;
    sample_en = 1'b0;
    flush = 1'b0;
    check("tbl_unf", 32'(underflow_cnt), 32'd1);
    check("tbl_ovf_flush", 32'(overflow_cnt), 32'd0);

    // Overflow: 10 writes into 8 slots, then read back.
    do_reset();
    for (int k = 0; k < 10; k++) push(32'hA0000000 + 32'(k));
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_cnt", 32'(overflow_cnt), 32'd2);
    for (int k = 0; k < 8; k++)
      strobe_check($sformatf("ovf_rd%0d", k), 32'hA0000000 + 32'(k));
    check("ovf_drained", 32'(fifo_level), 32'd0);

    // Simultaneous push and pop while full.
    do_reset();
    for (int k = 0; k < 8; k++) push(32'hB0000000 + 32'(k));
    step();
    wr_en = 1'b1;
    wr_data = 32'hC0DEC0DE;
    sample_en = 1'b1;
    step();
    wr_en = 1'b0;
    sample_en = 1'b0;
    check("pp_level", 32'(fifo_level), 32'd8);
    check("pp_ovf", 32'(overflow_cnt), 32'd0);
    check("pp_valid", 32'(dac_valid), 32'd1);
    check("pp_data", {dac_i, dac_q}, 32'hB0000000);
    for (int k = 1; k < 8; k++)
      strobe_check($sformatf("pp_rd%0d", k), 32'hB0000000 + 32'(k));
    strobe_check("pp_rd_new", 32'hC0DEC0DE);

    // Packet loss events.
    do_reset();
    packet_loss_i = 1'b1;
    repeat (3) step();
    packet_loss_i = 1'b0;
    repeat (2) step();
    packet_loss_i = 1'b1;
    step();
    packet_loss_i = 1'b0;
    repeat (3) step();
    check("loss_cnt", 32'(loss_cnt), 32'd2);

    // Overflow saturation, then clear with a same-cycle event.
    for (int k = 0; k < 8; k++) push(32'hE0000000 + 32'(k));
    wr_en = 1'b1;
    wr_data = 32'hFFFFFFFF;
    repeat (70000) step();
    check("sat_ovf", 32'(overflow_cnt), 32'h0000FFFF);
    check("sat_loss", 32'(loss_cnt), 32'd2);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    wr_en = 1'b0;
    check("clr_ovf", 32'(overflow_cnt), 32'd0);
    check("clr_loss", 32'(loss_cnt), 32'd0);
    check("clr_unf", 32'(underflow_cnt), 32'd0);
    step();
    check("clr_ovf_hold", 32'(overflow_cnt), 32'd0);

    // Reset mid-stream with a concurrent write.
    strobe_check("mid_rd", 32'hE0000000);
    reset = 1'b1;
    wr_en = 1'b1;
    wr_data = 32'h12345678;
    step();
    reset = 1'b0;
    wr_en = 1'b0;
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_stream", 32'(streaming), 32'd0);
    check("mrst_valid", 32'(dac_valid), 32'd0);
    check("mrst_dac", {dac_i, dac_q}, 32'h0);
    for (int k = 0; k < 4; k++) push(32'h0D0D0000 + 32'(k));
    step();
    check("mrst_stream2", 32'(streaming), 32'd1);
    strobe_check("mrst_rd0", 32'h0D0D0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
